// File: rtl/pe_cmd_arbiter.sv
// pe_cmd_arbiter: round-robin command arbiter and sequencer in front of the
// simple PE configuration port. One command is in flight at a time; WRITE,
// READ and EXEC commands are turned into timed PE cycles and a tagged response.
// Optional build macro PE_ARB_STATS_EN adds saturating response/error counters
// (stat_cmds, stat_errs).
module pe_cmd_arbiter #(
   parameter int NREQ   = 2,
   parameter int OP_LAT = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [2*NREQ-1:0]        req_op,
   input  logic [32*NREQ-1:0]       req_addr,
   input  logic [32*NREQ-1:0]       req_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [31:0]              rsp_data,
   output logic                     rsp_err,
   output logic                     busy,
   output logic [31:0]              pe_cfg_addr,
   output logic [31:0]              pe_cfg_wdata,
   output logic                     pe_cfg_we,
   output logic                     pe_cfg_en,
   input  logic [31:0]              pe_cfg_rdata
`ifdef PE_ARB_STATS_EN
   ,
   output logic [15:0]              stat_cmds,
   output logic [15:0]              stat_errs
`endif
);

   localparam int          IDW = $clog2(NREQ);
   localparam int          CW  = $clog2(OP_LAT + 1);
   localparam int unsigned NR  = NREQ;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RDADDR,
      S_RDCAP,
      S_RESP
   } state_t;

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_READ  = 2'b01,
      OP_EXEC  = 2'b10,
      OP_RSVD  = 2'b11
   } op_t;

   state_t           r_state;
   state_t           w_next;
   op_t              r_op;
   logic [IDW-1:0]   r_last_grant;
   logic [IDW-1:0]   r_id;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [31:0]      r_rsp_data;
   logic             r_rsp_err;
   logic [CW-1:0]    r_cnt;

   logic             w_grant_any;
   logic [IDW-1:0]   w_grant_idx;
   logic [IDW-1:0]   w_j;
   logic             w_accept;
   logic [31:0]      w_rd_addr;

   assign w_accept  = (r_state == S_IDLE) && w_grant_any;
   // READ reads back the full address; EXEC reads only the destination register field
   assign w_rd_addr = (r_op == OP_EXEC) ? {27'b0, r_addr[4:0]} : r_addr;

   assign rsp_valid = (r_state == S_RESP);
   assign busy      = (r_state != S_IDLE);
   assign rsp_id    = r_id;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;

   // Round-robin pick: first valid requester searching upward from last_grant+1
   always_comb begin
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      w_j         = '0;
      for (int unsigned k = 1; k <= NR; k++) begin
         w_j = IDW'((32'(r_last_grant) + k) % NR);
         if (!w_grant_any && req_valid[w_j]) begin
            w_grant_any = 1'b1;
            w_grant_idx = w_j;
         end
      end
   end

   // Accept strobe: one-hot to the winner, only while idle
   always_comb begin
      req_ready = '0;
      if (w_accept) begin
         req_ready[w_grant_idx] = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and PE port drive; PE outputs are zero outside ISSUE/RDADDR/RDCAP
   always_comb begin
      w_next       = r_state;
      pe_cfg_addr  = '0;
      pe_cfg_wdata = '0;
      pe_cfg_we    = 1'b0;
      pe_cfg_en    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_grant_any) begin
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            unique case (r_op)
               OP_WRITE: begin
                  pe_cfg_addr  = r_addr;
                  pe_cfg_wdata = r_wdata;
                  pe_cfg_we    = 1'b1;
                  w_next       = S_RESP;
               end
               OP_READ: begin
                  w_next = S_RDADDR;
               end
               OP_EXEC: begin
                  pe_cfg_addr  = r_addr;
                  pe_cfg_wdata = r_wdata;
                  pe_cfg_we    = 1'b1;
                  pe_cfg_en    = 1'b1;
                  w_next       = S_WAIT;
               end
               default: begin
                  w_next = S_RESP;
               end
            endcase
         end
         S_WAIT: begin
            if (r_cnt == CW'(1)) begin
               w_next = S_RDADDR;
            end
         end
         S_RDADDR: begin
            pe_cfg_addr = w_rd_addr;
            w_next      = S_RDCAP;
         end
         S_RDCAP: begin
            pe_cfg_addr = w_rd_addr;
            w_next      = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Command latch, latency counter and response capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= IDW'(NREQ - 1);
         r_id         <= '0;
         r_op         <= OP_WRITE;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
         r_cnt        <= '0;
      end else begin
         if (w_accept) begin
            r_last_grant <= w_grant_idx;
            r_id         <= w_grant_idx;
            r_op         <= op_t'(req_op[2*w_grant_idx +: 2]);
            r_addr       <= req_addr[32*w_grant_idx +: 32];
            r_wdata      <= req_wdata[32*w_grant_idx +: 32];
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
         end
         if (r_state == S_ISSUE) begin
            r_cnt     <= CW'(OP_LAT);
            r_rsp_err <= (r_op == OP_RSVD);
         end
         if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (r_state == S_RDCAP) begin
            r_rsp_data <= pe_cfg_rdata;
         end
      end
   end

`ifdef PE_ARB_STATS_EN
   logic [15:0] r_stat_cmds;
   logic [15:0] r_stat_errs;

   assign stat_cmds = r_stat_cmds;
   assign stat_errs = r_stat_errs;

   // Saturating counters of completed responses and of reserved-op responses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_cmds <= '0;
         r_stat_errs <= '0;
      end else if (rsp_valid && rsp_ready) begin
         if (r_stat_cmds != '1) begin
            r_stat_cmds <= r_stat_cmds + 16'd1;
         end
         if (r_rsp_err && (r_stat_errs != '1)) begin
            r_stat_errs <= r_stat_errs + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pe_cmd_arbiter.sv
// Bench for pe_cmd_arbiter: a small PE register-file model sits on the cfg
// port, and a cycle-level reference model predicts grants, PE strobes and
// responses from the command timing rules. Directed tests pin literal values;
// a randomized phase then exercises contention and backpressure.
// Optional build macro PE_ARB_STATS_EN enables the statistics checks.
module tb_pe_cmd_arbiter;
   localparam int NREQ   = 3;
   localparam int OP_LAT = 2;
   localparam int IDW    = $clog2(NREQ);

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [2*NREQ-1:0]    req_op = '0;
   logic [32*NREQ-1:0]   req_addr = '0;
   logic [32*NREQ-1:0]   req_wdata = '0;
   logic                 rsp_valid;
   logic                 rsp_ready = 1'b1;
   logic [IDW-1:0]       rsp_id;
   logic [31:0]          rsp_data;
   logic                 rsp_err;
   logic                 busy;
   logic [31:0]          pe_cfg_addr;
   logic [31:0]          pe_cfg_wdata;
   logic                 pe_cfg_we;
   logic                 pe_cfg_en;
   logic [31:0]          pe_cfg_rdata = '0;
`ifdef PE_ARB_STATS_EN
   logic [15:0]          stat_cmds;
   logic [15:0]          stat_errs;
`endif

   pe_cmd_arbiter #(.NREQ(NREQ), .OP_LAT(OP_LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
      .pe_cfg_addr(pe_cfg_addr), .pe_cfg_wdata(pe_cfg_wdata),
      .pe_cfg_we(pe_cfg_we), .pe_cfg_en(pe_cfg_en), .pe_cfg_rdata(pe_cfg_rdata)
`ifdef PE_ARB_STATS_EN
      , .stat_cmds(stat_cmds), .stat_errs(stat_errs)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // PE execute semantics: addr[24:20] function, [19:15] rs1, [14:10] rs2, [4:0] rd
   function automatic logic [31:0] pe_alu(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b);
      case (fn)
         5'd1:    return a + b;
         5'd2:    return a - b;
         5'd3:    return a * b;
         default: return a;
      endcase
   endfunction

   // PE register file on the cfg port; read data is registered (one cycle)
   logic [31:0] pe_regs [32] = '{default: '0};
   always @(posedge clk) begin
      if (pe_cfg_we)
         pe_regs[pe_cfg_addr[4:0]] <= pe_cfg_en ?
            pe_alu(pe_cfg_addr[24:20], pe_regs[pe_cfg_addr[19:15]], pe_regs[pe_cfg_addr[14:10]]) :
            pe_cfg_wdata;
      pe_cfg_rdata <= pe_regs[pe_cfg_addr[4:0]];
   end

   function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
      for (int k = 1; k <= NREQ; k++)
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      return 0;
   endfunction

   // Reference model state: one command in flight, described by accept cycle and opcode
   int             m_last = NREQ - 1;
   bit             m_busy = 1'b0;
   int             m_T = 0;
   int             m_R = 0;
   int             m_id = 0;
   logic [1:0]     m_op = '0;
   logic [31:0]    m_addr = '0;
   logic [31:0]    m_wd = '0;
   logic [31:0]    m_data = '0;
   logic           m_err = 1'b0;
   logic [31:0]    m_regs [32] = '{default: '0};
   logic [NREQ-1:0] g_grant = '0;
   int             n_we = 0;
   int             n_en = 0;

   // Compare process: mid-cycle check of every output against the model
   always @(negedge clk) begin
      logic [NREQ-1:0] e_ready;
      logic [31:0]     e_addr, e_wd, res;
      logic            e_we, e_en, e_rv;
      int              d, g;
      if (pe_cfg_we) n_we++;
      if (pe_cfg_en) n_en++;
      if (rst) begin
         chk("rst_req_ready", 32'(req_ready), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_rsp_id",    32'(rsp_id),    32'd0);
         chk("rst_rsp_data",  rsp_data,       32'd0);
         chk("rst_rsp_err",   32'(rsp_err),   32'd0);
         chk("rst_busy",      32'(busy),      32'd0);
         chk("rst_pe",        {pe_cfg_addr[29:0], pe_cfg_we, pe_cfg_en} | pe_cfg_wdata, 32'd0);
         m_busy  = 1'b0;
         m_last  = NREQ - 1;
         g_grant = '0;
      end else begin
         e_ready = '0;
         if (!m_busy && req_valid != '0) e_ready[rr_pick(m_last, req_valid)] = 1'b1;
         d    = cyc - m_T;
         e_rv = m_busy && (d >= m_R);
         e_addr = '0; e_wd = '0; e_we = 1'b0; e_en = 1'b0;
         if (m_busy) begin
            if (d == 1 && (m_op == 2'b00 || m_op == 2'b10)) begin
               e_addr = m_addr; e_wd = m_wd; e_we = 1'b1; e_en = (m_op == 2'b10);
            end
            if (m_op == 2'b01 && (d == 2 || d == 3)) e_addr = m_addr;
            if (m_op == 2'b10 && (d == 2 + OP_LAT || d == 3 + OP_LAT)) e_addr = {27'b0, m_addr[4:0]};
         end
         chk("req_ready", 32'(req_ready), 32'(e_ready));
         chk("busy",      32'(busy),      32'(m_busy));
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
         if (e_rv) begin
            chk("rsp_id",   32'(rsp_id),  32'(m_id));
            chk("rsp_data", rsp_data,     m_data);
            chk("rsp_err",  32'(rsp_err), 32'(m_err));
         end
         chk("pe_addr",  pe_cfg_addr,       e_addr);
         chk("pe_wdata", pe_cfg_wdata,      e_wd);
         chk("pe_we",    32'(pe_cfg_we),    32'(e_we));
         chk("pe_en",    32'(pe_cfg_en),    32'(e_en));
         g_grant = req_ready;
         if (e_ready != '0) begin
            g      = rr_pick(m_last, req_valid);
            m_last = g;
            m_id   = g;
            m_op   = req_op[2*g +: 2];
            m_addr = req_addr[32*g +: 32];
            m_wd   = req_wdata[32*g +: 32];
            m_T    = cyc;
            m_busy = 1'b1;
            m_data = '0;
            m_err  = 1'b0;
            case (m_op)
               2'b00: begin m_R = 2; m_regs[m_addr[4:0]] = m_wd; end
               2'b01: begin m_R = 4; m_data = m_regs[m_addr[4:0]]; end
               2'b10: begin
                  m_R = 4 + OP_LAT;
                  res = pe_alu(m_addr[24:20], m_regs[m_addr[19:15]], m_regs[m_addr[14:10]]);
                  m_regs[m_addr[4:0]] = res;
                  m_data = res;
               end
               default: begin m_R = 2; m_err = 1'b1; end
            endcase
         end else if (e_rv && rsp_ready) begin
            m_busy = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic mid();
      @(negedge clk); #1;
   endtask

   task automatic set_req(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd);
      req_valid[r]       = 1'b1;
      req_op[2*r +: 2]   = op;
      req_addr[32*r +: 32]  = a;
      req_wdata[32*r +: 32] = wd;
   endtask

   task automatic wait_grant(input int r, output int t);
      bit got = 1'b0;
      t = 0;
      for (int k = 0; k < 60 && !got; k++) begin
         mid();
         if (g_grant[r]) begin got = 1'b1; t = cyc; end
      end
      if (!got) chk("grant_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_rsp(input int t0, output int lat);
      bit got = 1'b0;
      lat = -1;
      for (int k = 0; k < 100 && !got; k++) begin
         mid();
         if (rsp_valid) begin got = 1'b1; lat = cyc - t0; end
      end
      if (!got) chk("rsp_timeout", 32'd0, 32'd1);
   endtask

   // Single command from requester r with rsp_ready high; returns response fields and latency
   task automatic do_cmd(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] data, output logic err, output int id, output int lat);
      int t0;
      tick();
      set_req(r, op, a, wd);
      wait_grant(r, t0);
      tick();
      req_valid[r] = 1'b0;
      wait_rsp(t0, lat);
      data = rsp_data;
      err  = rsp_err;
      id   = int'(rsp_id);
   endtask

   initial begin
      logic [31:0] data, d0;
      logic        err;
      int          id, lat, t0, w0, e0, nord;
      int          order [6];
`ifdef PE_ARB_STATS_EN
      logic [15:0] c0;
`endif
      repeat (3) tick();
      rst = 1'b0;

      // Two writes: R1=10 from req0, R2=20 from req1
      w0 = n_we; e0 = n_en;
      do_cmd(0, 2'b00, 32'd1, 32'd10, data, err, id, lat);
      chk("wr0_id", 32'(id), 32'd0); chk("wr0_data", data, 32'd0); chk("wr0_lat", 32'(lat), 32'd2);
      do_cmd(1, 2'b00, 32'd2, 32'd20, data, err, id, lat);
      chk("wr1_id", 32'(id), 32'd1); chk("wr1_data", data, 32'd0);
      chk("wr_we_count", 32'(n_we - w0), 32'd2); chk("wr_en_count", 32'(n_en - e0), 32'd0);

      // EXEC ADD R4 = R1 + R2
      e0 = n_en;
      do_cmd(0, 2'b10, {7'd1, 5'd1, 5'd1, 5'd2, 5'd0, 5'd4}, 32'd0, data, err, id, lat);
      chk("add_data", data, 32'd30); chk("add_lat", 32'(lat), 32'd6);
      chk("add_en_count", 32'(n_en - e0), 32'd1);
      do_cmd(1, 2'b10, {7'd0, 5'd2, 5'd1, 5'd2, 5'd0, 5'd5}, 32'd0, data, err, id, lat);
      chk("sub_data", data, 32'hFFFF_FFF6);
      do_cmd(0, 2'b10, {7'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd6}, 32'd0, data, err, id, lat);
      chk("mul_data", data, 32'd200);

      // READ of R4 with the response held off for five cycles while req0 waits
      tick();
      rsp_ready = 1'b0;
      set_req(1, 2'b01, 32'hABCD_E004, 32'd0);
      wait_grant(1, t0);
      tick();
      req_valid[1] = 1'b0;
      set_req(0, 2'b00, 32'd9, 32'd99);
      wait_rsp(t0, lat);
      d0 = rsp_data;
      chk("rd_data", d0, 32'd30); chk("rd_lat", 32'(lat), 32'd4);
      for (int k = 0; k < 5; k++) begin
         mid();
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_data",  rsp_data, d0);
         chk("stall_ready", 32'(req_ready), 32'd0);
      end
      tick();
      rsp_ready = 1'b1;
      req_valid[0] = 1'b0;
      tick();

      // Reset asserted while an EXEC sits in WAIT
      set_req(2, 2'b10, {7'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd7}, 32'd0);
      wait_grant(2, t0);
      tick();
      req_valid[2] = 1'b0;
      tick();
      chk("wait_busy", 32'(busy), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_pe", {pe_cfg_addr[29:0], pe_cfg_we, pe_cfg_en} | pe_cfg_wdata, 32'd0);
      chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      tick(); tick();
      rst = 1'b0;
      w0 = n_we + n_en;
      repeat (10) tick();
      chk("post_rst_strobes", 32'(n_we + n_en - w0), 32'd0);

      // Reserved opcode
      w0 = n_we + n_en;
`ifdef PE_ARB_STATS_EN
      c0 = stat_cmds;
`endif
      do_cmd(1, 2'b11, 32'h1234_5678, 32'd9, data, err, id, lat);
      chk("rsv_err", 32'(err), 32'd1); chk("rsv_lat", 32'(lat), 32'd2); chk("rsv_data", data, 32'd0);
      chk("rsv_strobes", 32'(n_we + n_en - w0), 32'd0);
`ifdef PE_ARB_STATS_EN
      tick();
      chk("stat_errs", 32'(stat_errs), 32'd1);
      chk("stat_cmds", 32'(stat_cmds), 32'(c0) + 32'd1);
`endif

      // All requesters valid continuously after reset: rotating grants
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      for (int r = 0; r < NREQ; r++) set_req(r, 2'b00, 32'(8 + r), 32'(100 + r));
      nord = 0;
      for (int k = 0; k < 80 && nord < 6; k++) begin
         mid();
         for (int r = 0; r < NREQ; r++)
            if (g_grant[r] && nord < 6) begin order[nord] = r; nord++; end
      end
      chk("rr_count", 32'(nord), 32'd6);
      for (int k = 0; k < 6; k++) chk("rr_order", 32'(order[k]), 32'(k % NREQ));
      tick();
      req_valid = '0;

      // Randomized contention with random response backpressure
      for (int c = 0; c < 3000; c++) begin
         tick();
         rsp_ready = ($urandom_range(0, 9) < 7);
         for (int r = 0; r < NREQ; r++) begin
            if (!req_valid[r] || g_grant[r]) begin
               if ($urandom_range(0, 3) != 0) begin
                  logic [1:0]  op;
                  logic [31:0] a;
                  int          sel = $urandom_range(0, 9);
                  op = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
                  a  = $urandom;
                  if (op == 2'b10)
                     a = {a[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), a[9:5], 5'($urandom_range(0, 7))};
                  else
                     a[4:0] = 5'($urandom_range(0, 7));
                  set_req(r, op, a, $urandom);
               end else begin
                  req_valid[r] = 1'b0;
               end
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[r] = 1'b0;
            end
         end
      end
      tick();
      req_valid = '0;
      rsp_ready = 1'b1;
      begin
         bit idle = 1'b0;
         for (int k = 0; k < 100 && !idle; k++) begin
            mid();
            if (!busy) idle = 1'b1;
         end
         chk("drain_idle", 32'(idle), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pe_cmd_arbiter.md
# pe_cmd_arbiter

Round-robin command arbiter and sequencer placed in front of the simple PE's configuration port (`cfg_addr`/`cfg_wdata`/`cfg_we`/`cfg_en`/`cfg_rdata`). Several requesters submit register-write, register-read or execute commands. The block grants one command at a time and drives the PE port with correctly timed cycles. For execute commands it waits the PE compute latency, reads back the destination register, and returns the result to the requester with an ID tag.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..8).
- `OP_LAT`, 2: cycles between the execute issue and the destination readback (≥1).

Ports:
- `clk`  in  1  single clock; every flop is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  command valid, one bit per requester.
- `req_ready`  out  NREQ  accept strobe, one-hot or zero.
- `req_op`  in  2*NREQ  opcode per requester: 00 WRITE, 01 READ, 10 EXEC, 11 reserved.
- `req_addr`  in  32*NREQ  PE cfg address word per requester.
- `req_wdata`  in  32*NREQ  write data per requester.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  clog2(NREQ)  index of the requester that issued the command.
- `rsp_data`  out  32  read or execute result; 0 for WRITE.
- `rsp_err`  out  1  set for a reserved opcode.
- `busy`  out  1  high whenever the state is not IDLE.
- `pe_cfg_addr`, `pe_cfg_wdata`  out  32  to PE.
- `pe_cfg_we`, `pe_cfg_en`  out  1  to PE.
- `pe_cfg_rdata`  in  32  from PE. Valid one cycle after the address is presented with `we`=0.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RDADDR, RDCAP, RESP.
- IDLE:
  - If any `req_valid` is high, grant round-robin, starting from `last_grant+1` modulo NREQ.
  - `req_ready[g]` is combinationally high in this cycle.
  - Latch op, addr, wdata and id. Set `last_grant`=g. Go to ISSUE.
- ISSUE: the block holds this state for one cycle.
  - WRITE: drive addr/wdata, `we`=1, `en`=0. Go to RESP with data 0.
  - READ: go to RDADDR. No PE strobe is driven in ISSUE.
  - EXEC: drive addr/wdata, `we`=1, `en`=1. Load the counter with OP_LAT. Go to WAIT.
  - Reserved (11): no PE activity. Go to RESP with `rsp_err`=1 and data 0.
- WAIT: the counter decrements each cycle. The block stays exactly OP_LAT cycles, then goes to RDADDR.
- RDADDR: drive `pe_cfg_addr` with `we`=0, `en`=0.
  - READ uses the latched addr.
  - EXEC uses {27'b0, addr[4:0]}, i.e. the destination register field.
  - Go to RDCAP.
- RDCAP: hold the same address. Capture `pe_cfg_rdata` into `rsp_data`. Go to RESP.
- RESP: `rsp_valid` is high and held stable until `rsp_ready`. The handshake cycle returns to IDLE. No new grant is made in that cycle.
- Outside ISSUE, RDADDR and RDCAP, all `pe_cfg_*` outputs are 0.
- Requesters must hold valid, op, addr and wdata stable until `req_ready`. Deasserting early is legal; the command is then simply not taken.

## Timing
- Accept in cycle T. ISSUE is T+1.
  - WRITE / reserved: `rsp_valid` from T+2.
  - READ: RDADDR T+2, RDCAP T+3, `rsp_valid` from T+4.
  - EXEC: WAIT T+2..T+1+OP_LAT, RDADDR T+2+OP_LAT, RDCAP T+3+OP_LAT, `rsp_valid` from T+4+OP_LAT.
- Throughput: at most one command in flight. With `rsp_ready` tied high, the next accept is at least one cycle after the RESP handshake.
- Reset values:
  - State IDLE; `last_grant`=NREQ-1, so requester 0 wins first.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, all `pe_cfg_*`=0.
- Reset mid-operation: everything returns to reset values immediately (asynchronously). The in-flight command and response are dropped, with no PE strobe after reset assertion.
- Simultaneous requests: exactly one grant per IDLE cycle. A continuously requesting set is served in rotating order, so no requester starves.
- `rsp_ready` held low: the FSM stalls in RESP and no further grants are made.

## Configuration
- `PE_ARB_STATS_EN` defined:
  - Adds output `stat_cmds` [15:0], incremented on each RESP handshake and saturating at 0xFFFF.
  - Adds output `stat_errs` [15:0], incremented on each handshake with `rsp_err`=1 and saturating.
  - Both reset to 0.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

## Test plan
- WRITE R1=10 from req0, then WRITE R2=20 from req1 → two responses, `rsp_id` 0 then 1, `rsp_data`=0; PE sees `we`=1, `en`=0 exactly once each.
- EXEC ADD addr {7'b1,5'b00001,5'd1,5'd2,5'd0,5'd4}, OP_LAT=2 → `rsp_valid` at T+6, `rsp_data`=30; `en` high for exactly one cycle.
- EXEC SUB into R5, then MUL into R6 → `rsp_data` 0xFFFFFFF6 (-10), then 200.
- All requesters valid every cycle with NREQ=3 → grant order 0,1,2,0,1,2; `req_ready` one-hot.
- `rsp_ready` low for 5 cycles during a READ response → `rsp_valid`/`rsp_data` stable, no new `req_ready`. Then assert `rst` in WAIT of an EXEC → `pe_cfg_*`=0 and `busy`=0 immediately; no response.
- Reserved op 11 → `rsp_err`=1 at T+2, no PE strobes. With `PE_ARB_STATS_EN`: `stat_errs`=1 and `stat_cmds` increments.
